// File: rtl/obi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : obi_arbiter
// Brief    : Two-master OBI arbiter (instr fetch + data load/store) onto one
//            shared memory port, with in-order response steering.
// Revision : 1.0 - initial release
// ============================================================================
module obi_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int DEPTH        = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        instr_req,
    input  logic [31:0] instr_addr,
    output logic        instr_gnt,
    output logic        instr_rvalid,
    output logic [31:0] instr_rdata,
    input  logic        data_req,
    input  logic        data_we,
    input  logic [3:0]  data_be,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_gnt,
    output logic        data_rvalid,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        err
);

    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_STV_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    localparam logic [c_CNT_W-1:0] c_DEPTH_V  = c_CNT_W'(DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(DEPTH - 1);
    localparam logic [c_STV_W-1:0] c_LIMIT_V  = c_STV_W'(STARVE_LIMIT);

    logic [DEPTH-1:0]   r_owner;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_CNT_W-1:0] r_count;
    logic [c_STV_W-1:0] r_starve;
    logic               r_err;

    logic w_full;
    logic w_empty;
    logic w_starved;
    logic w_sel_data;
    logic w_hs;
    logic w_pop;
    logic w_head;

    function automatic logic [c_PTR_W-1:0] f_ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign w_full     = (r_count == c_DEPTH_V);
    assign w_empty    = (r_count == '0);
    assign w_starved  = (r_starve == c_LIMIT_V);
    // Data has priority unless the fetch side has been starved long enough.
    assign w_sel_data = data_req & ~(instr_req & w_starved);

    assign mem_req    = (instr_req | data_req) & ~w_full & rstn;
    assign w_hs       = mem_req & mem_gnt;
    assign instr_gnt  = w_hs & ~w_sel_data;
    assign data_gnt   = w_hs & w_sel_data;

    assign mem_addr   = w_sel_data ? data_addr  : instr_addr;
    assign mem_we     = w_sel_data ? data_we    : 1'b0;
    assign mem_be     = w_sel_data ? data_be    : 4'hF;
    assign mem_wdata  = w_sel_data ? data_wdata : 32'h0;

    // Responses are steered by the oldest outstanding owner; strays are dropped.
    assign w_pop        = mem_rvalid & ~w_empty;
    assign w_head       = r_owner[r_rptr];
    assign instr_rvalid = w_pop & ~w_head;
    assign data_rvalid  = w_pop & w_head;
    assign instr_rdata  = mem_rdata;
    assign data_rdata   = mem_rdata;
    assign err          = r_err;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_owner  <= '0;
            r_rptr   <= '0;
            r_wptr   <= '0;
            r_count  <= '0;
            r_starve <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_hs) begin
                r_owner[r_wptr] <= w_sel_data;
                r_wptr          <= f_ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= f_ptr_inc(r_rptr);
            end
            if (w_hs && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_hs && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            if (mem_rvalid && w_empty) begin
                r_err <= 1'b1;
            end
            if (!instr_req || instr_gnt) begin
                r_starve <= '0;
            end else if (data_gnt && !w_starved) begin
                r_starve <= r_starve + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_obi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_obi_arbiter
// Brief    : Self-checking bench for obi_arbiter against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_obi_arbiter;

    localparam int STARVE_LIMIT = 4;
    localparam int DEPTH        = 2;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        instr_req = 1'b0;
    logic [31:0] instr_addr = '0;
    logic        instr_gnt, instr_rvalid;
    logic [31:0] instr_rdata;
    logic        data_req = 1'b0, data_we = 1'b0;
    logic [3:0]  data_be = '0;
    logic [31:0] data_addr = '0, data_wdata = '0;
    logic        data_gnt, data_rvalid;
    logic [31:0] data_rdata;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        err;

    obi_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn),
        .instr_req(instr_req), .instr_addr(instr_addr), .instr_gnt(instr_gnt),
        .instr_rvalid(instr_rvalid), .instr_rdata(instr_rdata),
        .data_req(data_req), .data_we(data_we), .data_be(data_be),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_gnt(data_gnt), .data_rvalid(data_rvalid), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .err(err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: outstanding owners in order (1 = data), consecutive
    // data wins while fetch waits, and the sticky error flag.
    bit mq[$];
    int m_starve = 0;
    bit m_err = 1'b0;
    bit e_req, e_sel_d, e_hs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_cycle(input string tag);
        bit head_v, head;
        #1;
        if (!rstn) begin
            mq.delete();
            m_starve = 0;
            m_err = 1'b0;
        end
        e_req   = (instr_req || data_req) && (mq.size() < DEPTH) && rstn;
        e_sel_d = data_req && !(instr_req && m_starve == STARVE_LIMIT);
        e_hs    = e_req && mem_gnt;
        head_v  = mem_rvalid && (mq.size() > 0);
        head    = (mq.size() > 0) ? mq[0] : 1'b0;
        chk({tag, ".mem_req"},      mem_req,      e_req);
        chk({tag, ".instr_gnt"},    instr_gnt,    e_hs && !e_sel_d);
        chk({tag, ".data_gnt"},     data_gnt,     e_hs && e_sel_d);
        chk({tag, ".instr_rvalid"}, instr_rvalid, head_v && !head);
        chk({tag, ".data_rvalid"},  data_rvalid,  head_v && head);
        chk({tag, ".err"},          err,          m_err);
        chk({tag, ".instr_rdata"},  instr_rdata,  mem_rdata);
        chk({tag, ".data_rdata"},   data_rdata,   mem_rdata);
        if (e_req) begin
            chk({tag, ".mem_addr"},  mem_addr,  e_sel_d ? data_addr  : instr_addr);
            chk({tag, ".mem_we"},    mem_we,    e_sel_d ? data_we    : 1'b0);
            chk({tag, ".mem_be"},    mem_be,    e_sel_d ? data_be    : 4'hF);
            chk({tag, ".mem_wdata"}, mem_wdata, e_sel_d ? data_wdata : 32'h0);
        end
        assert (!(instr_rvalid && data_rvalid)) else begin
            n_mis++;
            $error("FAIL %s.both_rvalid observed=1 expected=0", tag);
        end
    endtask

    task automatic advance();
        if (rstn) begin
            if (mem_rvalid) begin
                if (mq.size() > 0) void'(mq.pop_front());
                else m_err = 1'b1;
            end
            if (e_hs) mq.push_back(e_sel_d);
            if (!instr_req || (e_hs && !e_sel_d)) m_starve = 0;
            else if (e_hs && e_sel_d && m_starve < STARVE_LIMIT) m_starve++;
        end
        @(negedge clk);
    endtask

    task automatic step(input string tag);
        chk_cycle(tag);
        advance();
    endtask

    task automatic idle();
        instr_req = 1'b0; data_req = 1'b0; data_we = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
    endtask

    task automatic drain(input string tag);
        idle();
        for (int i = 0; i < 8 && mq.size() > 0; i++) begin
            mem_rvalid = 1'b1;
            mem_rdata = $urandom;
            step(tag);
        end
        mem_rvalid = 1'b0;
        chk({tag, ".empty"}, mq.size(), 0);
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        step("reset");
        chk("reset.mem_req_const", mem_req, 1'b0);
        rstn = 1'b1;

        // Single fetch, response one cycle later
        instr_req = 1'b1; instr_addr = 32'h100; mem_gnt = 1'b1;
        chk_cycle("fetch0");
        chk("fetch0.gnt_const", instr_gnt, 1'b1);
        chk("fetch0.addr_const", mem_addr, 32'h100);
        advance();
        idle();
        mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
        chk_cycle("fetch1");
        chk("fetch1.rvalid_const", instr_rvalid, 1'b1);
        chk("fetch1.rdata_const", instr_rdata, 32'hDEADBEEF);
        chk("fetch1.data_rvalid_const", data_rvalid, 1'b0);
        advance();
        idle();

        // Fill to DEPTH, then full blocks even with an arriving response
        data_req = 1'b1; data_addr = 32'h40; mem_gnt = 1'b1;
        for (int i = 0; i < DEPTH; i++) step("fill");
        chk_cycle("full");
        chk("full.mem_req_const", mem_req, 1'b0);
        advance();
        mem_rvalid = 1'b1;
        chk_cycle("full_rv");
        chk("full_rv.no_bypass", data_gnt, 1'b0);
        advance();
        mem_rvalid = 1'b0;
        chk_cycle("refill");
        chk("refill.gnt_const", data_gnt, 1'b1);
        advance();
        drain("drain1");

        // Data write then fetch, in-order responses
        data_req = 1'b1; data_we = 1'b1; data_be = 4'b0011;
        data_addr = 32'h200; data_wdata = 32'hCAFE0001; mem_gnt = 1'b1;
        chk_cycle("wr");
        chk("wr.be_const", mem_be, 4'b0011);
        advance();
        data_req = 1'b0; data_we = 1'b0;
        instr_req = 1'b1; instr_addr = 32'h300;
        step("rd");
        idle();
        mem_rvalid = 1'b1;
        chk_cycle("resp0");
        chk("resp0.data_first", data_rvalid, 1'b1);
        advance();
        chk_cycle("resp1");
        chk("resp1.instr_second", instr_rvalid, 1'b1);
        advance();
        mem_rvalid = 1'b0;
        chk("order.empty", mq.size(), 0);

        // Starvation: D,D,D,D,I repeating
        idle();
        step("pre_starve");
        instr_req = 1'b1; data_req = 1'b1; mem_gnt = 1'b1;
        for (int i = 0; i < 15; i++) begin
            mem_rvalid = (i > 0);
            mem_rdata = $urandom;
            chk_cycle("starve");
            chk("starve.pattern", instr_gnt, (i % 5) == 4);
            advance();
        end
        drain("drain2");

        // Randomized traffic with responses only when something is outstanding
        for (int i = 0; i < 400; i++) begin
            instr_req  = 1'($urandom);
            data_req   = 1'($urandom);
            data_we    = 1'($urandom);
            data_be    = 4'($urandom);
            instr_addr = $urandom;
            data_addr  = $urandom;
            data_wdata = $urandom;
            mem_gnt    = ($urandom_range(0, 3) != 0);
            mem_rvalid = (mq.size() > 0) && 1'($urandom);
            mem_rdata  = $urandom;
            step("rand");
        end
        drain("drain3");

        // Stray response sets sticky err
        mem_rvalid = 1'b1;
        chk_cycle("stray");
        chk("stray.no_rvalid", instr_rvalid | data_rvalid, 1'b0);
        advance();
        mem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_cycle("sticky");
            chk("sticky.err_const", err, 1'b1);
            advance();
        end
        rstn = 1'b0;
        step("err_reset");
        rstn = 1'b1;

        // Reset mid-operation discards outstanding entries
        data_req = 1'b1; mem_gnt = 1'b1;
        step("out0");
        step("out1");
        idle();
        rstn = 1'b0;
        chk_cycle("mid_reset");
        chk("mid_reset.err_const", err, 1'b0);
        advance();
        rstn = 1'b1;
        instr_req = 1'b1; instr_addr = 32'h500; mem_gnt = 1'b1;
        chk_cycle("post_reset");
        chk("post_reset.gnt_const", instr_gnt, 1'b1);
        advance();
        idle();
        mem_rvalid = 1'b1;
        chk_cycle("post_resp");
        chk("post_resp.instr_const", instr_rvalid, 1'b1);
        advance();
        chk_cycle("post_stray");
        chk("post_stray.no_rvalid", data_rvalid | instr_rvalid, 1'b0);
        advance();
        mem_rvalid = 1'b0;
        chk_cycle("post_err");
        chk("post_err.err_const", err, 1'b1);
        advance();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
